// File: rtl/inst_mem_ctrl.sv
// Writable instruction memory with registered req/ready/valid fetch, self-clear after reset
// and a sequential program-load port. Optional word parity via `INST_PARITY_EN.
module inst_mem_ctrl #(
    parameter int ADDR_W = 4,
    parameter int INST_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [INST_W-1:0] inst_o,
    input  logic              load_start_i,
    input  logic              load_valid_i,
    input  logic              load_last_i,
    input  logic [INST_W-1:0] load_data_i,
`ifdef INST_PARITY_EN
    input  logic              load_par_flip_i,
    output logic              parity_err_o,
`endif
    output logic              load_done_o,
    output logic              busy_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_RUN,
        S_LOAD
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
    logic              valid_q, valid_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              done_q, done_d;

    logic [INST_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [INST_W-1:0] mem_wdata;

`ifdef INST_PARITY_EN
    logic              par_mem_q [DEPTH];
    logic              mem_wpar;
    logic              perr_q, perr_d;
`endif

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        load_ptr_d = load_ptr_q;
        valid_d    = 1'b0;
        inst_d     = inst_q;
        done_d     = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = clr_ptr_q;
        mem_wdata  = '0;
`ifdef INST_PARITY_EN
        mem_wpar   = 1'b0;
        perr_d     = 1'b0;
`endif

        case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (req_i) begin
                    valid_d = 1'b1;
                    inst_d  = mem_q[addr_i];
`ifdef INST_PARITY_EN
                    perr_d  = par_mem_q[addr_i] != (^mem_q[addr_i]);
`endif
                end
                if (load_start_i) begin
                    state_d    = S_LOAD;
                    load_ptr_d = '0;
                end
            end

            S_LOAD: begin
                if (load_valid_i) begin
                    mem_we    = 1'b1;
                    mem_waddr = load_ptr_q;
                    mem_wdata = load_data_i;
`ifdef INST_PARITY_EN
                    mem_wpar  = (^load_data_i) ^ load_par_flip_i;
`endif
                    // Completion on the flagged word or on the last address, whichever comes first.
                    if (load_last_i || (load_ptr_q == LAST_ADDR)) begin
                        done_d     = 1'b1;
                        load_ptr_d = '0;
                        state_d    = S_RUN;
                    end else begin
                        load_ptr_d = load_ptr_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_CLEAR;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_CLEAR;
            clr_ptr_q  <= '0;
            load_ptr_q <= '0;
            valid_q    <= 1'b0;
            inst_q     <= '0;
            done_q     <= 1'b0;
`ifdef INST_PARITY_EN
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            load_ptr_q <= load_ptr_d;
            valid_q    <= valid_d;
            inst_q     <= inst_d;
            done_q     <= done_d;
`ifdef INST_PARITY_EN
            perr_q     <= perr_d;
`endif
        end
    end

    // NOTE: the array has no reset; the CLEAR sweep zeroes it, keeping it mappable to RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
`ifdef INST_PARITY_EN
            par_mem_q[mem_waddr] <= mem_wpar;
`endif
        end
    end

    assign ready_o     = (state_q == S_RUN);
    assign busy_o      = (state_q != S_RUN);
    assign valid_o     = valid_q;
    assign inst_o      = inst_q;
    assign load_done_o = done_q;
`ifdef INST_PARITY_EN
    assign parity_err_o = perr_q;
`endif

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Self-checking bench for inst_mem_ctrl: directed scenarios plus randomized traffic,
// all compared each cycle against a behavioural memory model. Parity checks under `INST_PARITY_EN.
module tb_inst_mem_ctrl;

    localparam int ADDR_W = 4;
    localparam int INST_W = 16;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic              load_start = 1'b0;
    logic              lv = 1'b0;
    logic              llast = 1'b0;
    logic [INST_W-1:0] ld = '0;
    logic              flip = 1'b0;
    logic              ready_o, valid_o, load_done_o, busy_o;
    logic [INST_W-1:0] inst_o;
`ifdef INST_PARITY_EN
    logic              parity_err_o;
`endif

    always #5 clk = ~clk;

    inst_mem_ctrl #(.ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req),
        .addr_i         (addr),
        .ready_o        (ready_o),
        .valid_o        (valid_o),
        .inst_o         (inst_o),
        .load_start_i   (load_start),
        .load_valid_i   (lv),
        .load_last_i    (llast),
        .load_data_i    (ld),
`ifdef INST_PARITY_EN
        .load_par_flip_i(flip),
        .parity_err_o   (parity_err_o),
`endif
        .load_done_o    (load_done_o),
        .busy_o         (busy_o)
    );

    // Behavioural model: a plain word array plus a mode and a pair of counters.
    typedef enum {M_CLEAR, M_RUN, M_LOAD} mode_e;
    mode_e             mode;
    int                clr_cnt;
    int                lidx;
    logic [INST_W-1:0] m  [DEPTH];
    logic              pm [DEPTH];
    logic              exp_valid, exp_done, exp_perr;
    logic [INST_W-1:0] exp_inst;

    int n_cmp = 0;
    int n_err = 0;

    logic [INST_W-1:0] ldw [DEPTH+1];
    logic              ldf [DEPTH+1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mode      = M_CLEAR;
        clr_cnt   = 0;
        lidx      = 0;
        exp_valid = 1'b0;
        exp_inst  = '0;
        exp_done  = 1'b0;
        exp_perr  = 1'b0;
    endtask

    task automatic model_update();
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        exp_perr  = 1'b0;
        case (mode)
            M_CLEAR: begin
                m[clr_cnt]  = '0;
                pm[clr_cnt] = 1'b0;
                clr_cnt++;
                if (clr_cnt == DEPTH) mode = M_RUN;
            end
            M_RUN: begin
                if (req) begin
                    exp_valid = 1'b1;
                    exp_inst  = m[addr];
                    exp_perr  = pm[addr] != (^m[addr]);
                end
                if (load_start) begin
                    mode = M_LOAD;
                    lidx = 0;
                end
            end
            M_LOAD: begin
                if (lv) begin
                    m[lidx]  = ld;
                    pm[lidx] = (^ld) ^ flip;
                    if (llast || lidx == DEPTH - 1) begin
                        exp_done = 1'b1;
                        mode     = M_RUN;
                        lidx     = 0;
                    end else begin
                        lidx++;
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic compare();
        check("ready_o", 32'(ready_o), 32'(mode == M_RUN));
        check("busy_o", 32'(busy_o), 32'(mode != M_RUN));
        check("valid_o", 32'(valid_o), 32'(exp_valid));
        check("inst_o", 32'(inst_o), 32'(exp_inst));
        check("load_done_o", 32'(load_done_o), 32'(exp_done));
`ifdef INST_PARITY_EN
        check("parity_err_o", 32'(parity_err_o), 32'(exp_perr));
`endif
    endtask

    // Inputs change at the negedge; the DUT and model consume them at the posedge.
    task automatic step();
        @(posedge clk);
        if (!rst) model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b1;
        model_reset();
        repeat (cycles) step();
        rst = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int want);
        int cnt = 0;
        while (!ready_o && cnt < 100) begin
            step();
            cnt++;
        end
        check(name, 32'(cnt), 32'(want));
    endtask

    task automatic fetch_check(input int a, input logic [INST_W-1:0] exp, input string name);
        addr = ADDR_W'(a);
        req  = 1'b1;
        step();
        req  = 1'b0;
        check({name, "_valid"}, 32'(valid_o), 32'd1);
        check(name, 32'(inst_o), 32'(exp));
    endtask

    task automatic load_words(input int n, input logic use_last);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        check("load_entry_ready", 32'(ready_o), 32'd0);
        for (int i = 0; i < n; i++) begin
            lv    = 1'b1;
            ld    = ldw[i];
            flip  = ldf[i];
            llast = use_last && (i == n - 1);
            step();
        end
        lv    = 1'b0;
        llast = 1'b0;
        flip  = 1'b0;
        check("load_done_pulse", 32'(load_done_o), 32'd1);
        step();
        check("load_done_low", 32'(load_done_o), 32'd0);
    endtask

    initial begin
        logic [INST_W-1:0] t2 [6];
        int                gap [5];
        int                wcnt;

        model_reset();
        for (int i = 0; i <= DEPTH; i++) ldf[i] = 1'b0;
        @(negedge clk);
        apply_reset(3);

        // 1: sixteen clear cycles, then everything reads as zero back to back.
        wait_ready("clear_cycles", 16);
        for (int a = 0; a < DEPTH; a++) fetch_check(a, 16'h0000, "fetch_cleared");

        // 2: six-word program terminated by load_last.
        t2[0] = 16'hFF89; t2[1] = 16'h0191; t2[2] = 16'h0A88;
        t2[3] = 16'h0A89; t2[4] = 16'h0A8A; t2[5] = 16'h0A8B;
        for (int i = 0; i < 6; i++) ldw[i] = t2[i];
        load_words(6, 1'b1);
        for (int a = 0; a < 6; a++) fetch_check(a, t2[a], "fetch_prog6");
        fetch_check(6, 16'h0000, "fetch_unwritten6");

        // 3: full-depth load completes on its own; an extra word in RUN is ignored.
        for (int i = 0; i <= DEPTH; i++) ldw[i] = 16'(16'h1000 + i * 16'h0111);
        load_words(DEPTH, 1'b0);
        lv = 1'b1;
        ld = ldw[DEPTH];
        step();
        lv = 1'b0;
        fetch_check(0, 16'h1000, "fetch_after_extra");
        fetch_check(15, 16'h1FFF, "fetch_last_word");

        // 4: stalls between load words.
        gap[0] = 1; gap[1] = 0; gap[2] = 0; gap[3] = 1; gap[4] = 1;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        wcnt = 0;
        for (int k = 0; k < 5; k++) begin
            lv    = (gap[k] == 1);
            ld    = 16'(16'hA000 + wcnt);
            llast = (k == 4);
            step();
            if (gap[k] == 1) wcnt++;
            if (k < 4) check("ready_during_gaps", 32'(ready_o), 32'd0);
        end
        lv    = 1'b0;
        llast = 1'b0;
        check("gap_done", 32'(load_done_o), 32'd1);
        fetch_check(0, 16'hA000, "fetch_gap0");
        fetch_check(1, 16'hA001, "fetch_gap1");
        fetch_check(2, 16'hA002, "fetch_gap2");
        fetch_check(3, 16'h1333, "fetch_kept3");

        // 5: fetch in the same cycle as load_start, then reset in the middle of a load.
        addr       = 4'd2;
        req        = 1'b1;
        load_start = 1'b1;
        step();
        req        = 1'b0;
        load_start = 1'b0;
        check("overlap_valid", 32'(valid_o), 32'd1);
        check("overlap_old_data", 32'(inst_o), 32'h0000A002);
        check("overlap_ready", 32'(ready_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            lv = 1'b1;
            ld = 16'(16'hBEE0 + i);
            step();
        end
        lv = 1'b0;
        apply_reset(2);
        wait_ready("clear_after_reset", 16);
        fetch_check(0, 16'h0000, "fetch_reset_cleared0");
        fetch_check(2, 16'h0000, "fetch_reset_cleared2");

`ifdef INST_PARITY_EN
        // 6: injected parity error on address 0 only.
        ldw[0] = 16'h0001; ldf[0] = 1'b1;
        ldw[1] = 16'h0003; ldf[1] = 1'b0;
        load_words(2, 1'b1);
        ldf[0] = 1'b0;
        fetch_check(0, 16'h0001, "par_fetch0");
        check("par_err0", 32'(parity_err_o), 32'd1);
        fetch_check(1, 16'h0003, "par_fetch1");
        check("par_err1", 32'(parity_err_o), 32'd0);
`endif

        // Randomized traffic, including stimulus during CLEAR and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            req        = 1'($urandom_range(0, 1));
            addr       = ADDR_W'($urandom_range(0, DEPTH - 1));
            load_start = ($urandom_range(0, 15) == 0);
            lv         = 1'($urandom_range(0, 1));
            llast      = ($urandom_range(0, 7) == 0);
            ld         = 16'($urandom);
            flip       = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 599) == 0) apply_reset(1);
            else step();
        end
        req        = 1'b0;
        load_start = 1'b0;
        lv         = 1'b0;
        llast      = 1'b0;
        flip       = 1'b0;
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
